// File: rtl/branch_predictor.sv
// branch_predictor: fetch-stage pre-decode of JAL / B-type / JALR with a bimodal
// table of 2-bit saturating counters for conditional branches and an optional
// return-address stack for JALR returns.
// Optional feature macro: BRANCH_PRED_RAS_EN (defined = RAS compiled in).
// Prediction outputs are combinational (zero-cycle) from Instruction/pc and the
// current table/stack state; all state updates on the rising clk edge.
module branch_predictor #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pipeline_update,
  input  logic [31:0]     Instruction,
  input  logic [XLEN-1:0] pc,
  output logic [2:0]      JUMP_TYPE,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic            flush
);

  localparam int unsigned IDX_W     = $clog2(BHT_DEPTH);
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [1:0]  CTR_INIT  = 2'b01;
  localparam logic [1:0]  CTR_MAX   = 2'b11;
  localparam logic [1:0]  CTR_MIN   = 2'b00;
  localparam logic [2:0]  JT_NONE   = 3'b000;
  localparam logic [2:0]  JT_JAL    = 3'b001;
  localparam logic [2:0]  JT_BRANCH = 3'b010;
  localparam logic [2:0]  JT_JALR   = 3'b100;

  // ---------------------------------------------------------------------------
  // Pre-decode
  // ---------------------------------------------------------------------------
  logic [6:0]      opcode;
  logic            is_jal;
  logic            is_br;
  logic            is_jalr;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] tgt_jal;
  logic [XLEN-1:0] tgt_br;

  // Qualified opcode match and PC-relative targets (modulo 2^XLEN)
  always_comb begin
    opcode  = Instruction[6:0];
    is_jal  = pipeline_update && (opcode == OP_JAL);
    is_br   = pipeline_update && (opcode == OP_BRANCH);
    is_jalr = pipeline_update && (opcode == OP_JALR);
    imm_j   = {{(XLEN-21){Instruction[31]}}, Instruction[31], Instruction[19:12],
               Instruction[20], Instruction[30:21], 1'b0};
    imm_b   = {{(XLEN-13){Instruction[31]}}, Instruction[31], Instruction[7],
               Instruction[30:25], Instruction[11:8], 1'b0};
    tgt_jal = pc + imm_j;
    tgt_br  = pc + imm_b;
  end

  // ---------------------------------------------------------------------------
  // Bimodal branch history table
  // ---------------------------------------------------------------------------
  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [1:0]       rd_ctr;
  logic [1:0]       upd_ctr;
  logic [1:0]       upd_next;

  // Table read for the fetched PC and saturating next value for the trained entry
  always_comb begin
    rd_idx   = pc[IDX_W+1:2];
    rd_ctr   = bht[rd_idx];
    upd_idx  = upd_pc[IDX_W+1:2];
    upd_ctr  = bht[upd_idx];
    upd_next = upd_ctr;
    if (upd_taken) begin
      if (upd_ctr != CTR_MAX) upd_next = upd_ctr + 2'd1;
    end else begin
      if (upd_ctr != CTR_MIN) upd_next = upd_ctr - 2'd1;
    end
  end

  // Counter storage: weak-not-taken after reset, single write port from execute
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
        bht[IDX_W'(i)] <= CTR_INIT;
      end
    end else if (upd_valid) begin
      bht[upd_idx] <= upd_next;
    end
  end

  // Only the index field of the resolved PC selects a counter
  logic unused_upd_pc;
  assign unused_upd_pc = ^{upd_pc[XLEN-1:IDX_W+2], upd_pc[1:0]};

  // ---------------------------------------------------------------------------
  // Return-address stack
  // ---------------------------------------------------------------------------
  logic            ras_hit_c;
  logic [XLEN-1:0] ras_top;

`ifdef BRANCH_PRED_RAS_EN
  localparam int unsigned RP_W  = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = RP_W + 1;

  logic [XLEN-1:0]  ras [RAS_DEPTH];
  logic [RP_W-1:0]  ras_ptr;
  logic [RP_W-1:0]  top_idx;
  logic [CNT_W-1:0] ras_cnt;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic             rd_link;
  logic             rs1_link;
  logic             push_req;
  logic             pop_req;
  logic             ras_empty;
  logic             ras_full;
  logic [XLEN-1:0]  link_addr;

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  // Call/return classification from the link-register hints
  always_comb begin
    rd        = Instruction[11:7];
    rs1       = Instruction[19:15];
    rd_link   = is_link(rd);
    rs1_link  = is_link(rs1);
    ras_empty = (ras_cnt == '0);
    ras_full  = (ras_cnt == CNT_W'(RAS_DEPTH));
    push_req  = (is_jal || is_jalr) && rd_link;
    pop_req   = is_jalr && rs1_link && (!rd_link || (rd != rs1));
    ras_hit_c = pop_req && !ras_empty;
    top_idx   = ras_ptr - RP_W'(1);
    ras_top   = ras[top_idx];
    link_addr = pc + XLEN'(4);
  end

  // Circular pointer and occupancy; flush wins over any same-cycle push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (flush) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (ras_hit_c && push_req) begin
      ras_ptr <= ras_ptr;
      ras_cnt <= ras_cnt;
    end else if (ras_hit_c) begin
      ras_ptr <= ras_ptr - RP_W'(1);
      ras_cnt <= ras_cnt - CNT_W'(1);
    end else if (push_req) begin
      ras_ptr <= ras_ptr + RP_W'(1);
      ras_cnt <= ras_full ? ras_cnt : ras_cnt + CNT_W'(1);
    end
  end

  // Entry storage: pop-then-push overwrites the top, a plain push writes the next slot
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (ras_hit_c && push_req) begin
        ras[top_idx] <= link_addr;
      end else if (push_req) begin
        ras[ras_ptr] <= link_addr;
      end
    end
  end
`else
  // No return stack: JALR never redirects and flush has nothing to clear
  assign ras_hit_c = 1'b0;
  assign ras_top   = '0;

  logic unused_flush;
  assign unused_flush = flush;
`endif

  // ---------------------------------------------------------------------------
  // Prediction
  // ---------------------------------------------------------------------------

  // Jump type, direction and target presented to the next-PC mux
  always_comb begin
    JUMP_TYPE   = JT_NONE;
    pred_taken  = 1'b0;
    pred_target = '0;
    if (is_jal) begin
      JUMP_TYPE   = JT_JAL;
      pred_taken  = 1'b1;
      pred_target = tgt_jal;
    end else if (is_br) begin
      JUMP_TYPE   = JT_BRANCH;
      pred_taken  = rd_ctr[1];
      pred_target = rd_ctr[1] ? tgt_br : '0;
    end else if (is_jalr) begin
      JUMP_TYPE   = JT_JALR;
      pred_taken  = ras_hit_c;
      pred_target = ras_hit_c ? ras_top : '0;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor. Reference model: an integer array of
// counter values (saturating arithmetic) and a bounded queue for the return stack.
// Build with +define+BRANCH_PRED_RAS_EN to exercise the return-address stack.
module tb_branch_predictor;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned BHT_DEPTH = 64;
  localparam int unsigned RAS_DEPTH = 4;
`ifdef BRANCH_PRED_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            pipeline_update;
  logic [31:0]     Instruction;
  logic [XLEN-1:0] pc;
  logic [2:0]      JUMP_TYPE;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic            flush;

  branch_predictor #(
    .XLEN(XLEN), .BHT_DEPTH(BHT_DEPTH), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pipeline_update(pipeline_update),
    .Instruction(Instruction), .pc(pc), .JUMP_TYPE(JUMP_TYPE),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          bht_m [BHT_DEPTH];
  logic [63:0] ras_q [$];

  // Current fetch stimulus in abstract form (0 none, 1 JAL, 2 B, 3 JALR)
  int          cur_kind;
  logic [63:0] cur_imm;
  logic [4:0]  cur_rd;
  logic [4:0]  cur_rs1;

  logic [2:0]  exp_type;
  logic        exp_taken;
  logic [63:0] exp_target;

  function automatic logic [31:0] enc_jal(input logic [4:0] r, input logic [20:0] im);
    return {im[20], im[10:1], im[11], im[19:12], r, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_br(input logic [12:0] im);
    return {im[12], im[10:5], 5'd3, 5'd2, 3'b000, im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] r, input logic [4:0] s, input logic [11:0] im);
    return {im, s, 3'b000, r, 7'b1100111};
  endfunction

  function automatic bit is_link_m(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic bit is_return_m(input logic [4:0] r, input logic [4:0] s);
    return is_link_m(s) && (!is_link_m(r) || (r != s));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < BHT_DEPTH; i++) bht_m[i] = 1;
    ras_q.delete();
  endtask

  // Expected outputs for the current inputs and model state
  task automatic predict();
    int idx;
    exp_type = 3'b000; exp_taken = 1'b0; exp_target = 64'd0;
    if (pipeline_update) begin
      case (cur_kind)
        1: begin exp_type = 3'b001; exp_taken = 1'b1; exp_target = pc + cur_imm; end
        2: begin
          exp_type = 3'b010;
          idx = int'((pc >> 2) % BHT_DEPTH);
          exp_taken = (bht_m[idx] >= 2);
          exp_target = exp_taken ? pc + cur_imm : 64'd0;
        end
        3: begin
          exp_type = 3'b100;
          if (RAS_ON && is_return_m(cur_rd, cur_rs1) && ras_q.size() > 0) begin
            exp_taken = 1'b1;
            exp_target = ras_q[$];
          end
        end
        default: ;
      endcase
    end
  endtask

  // Advance one clock, applying the same-cycle effects to the model
  task automatic cycle();
    int idx;
    if (rst_n) begin
      if (upd_valid) begin
        idx = int'((upd_pc >> 2) % BHT_DEPTH);
        if (upd_taken) bht_m[idx] = (bht_m[idx] < 3) ? bht_m[idx] + 1 : 3;
        else           bht_m[idx] = (bht_m[idx] > 0) ? bht_m[idx] - 1 : 0;
      end
      if (RAS_ON) begin
        if (flush) ras_q.delete();
        else if (pipeline_update) begin
          if (cur_kind == 3 && is_return_m(cur_rd, cur_rs1) && ras_q.size() > 0)
            void'(ras_q.pop_back());
          if ((cur_kind == 1 || cur_kind == 3) && is_link_m(cur_rd)) begin
            ras_q.push_back(pc + 64'd4);
            if (ras_q.size() > RAS_DEPTH) void'(ras_q.pop_front());
          end
        end
      end
    end else begin
      model_reset();
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch(input int kind, input logic [63:0] imm, input logic [4:0] r_d,
                       input logic [4:0] r_s1, input logic [63:0] addr);
    logic [31:0] tmp;
    logic [6:0]  ops [5];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0110111};
    tmp = $urandom();
    pipeline_update = 1'b1;
    pc = addr;
    cur_kind = kind; cur_imm = imm; cur_rd = r_d; cur_rs1 = r_s1;
    case (kind)
      1: Instruction = enc_jal(r_d, imm[20:0]);
      2: Instruction = enc_br(imm[12:0]);
      3: Instruction = enc_jalr(r_d, r_s1, imm[11:0]);
      default: Instruction = {tmp[31:7], ops[$urandom_range(0, 4)]};
    endcase
  endtask

  task automatic idle();
    pipeline_update = 1'b0;
    cur_kind = 0;
    Instruction = $urandom();
    pc = {$urandom(), $urandom()};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; flush = 1'b0;
    idle();
    model_reset();
    @(negedge clk); #1;
    checks++; if (JUMP_TYPE !== 3'b000) begin errors++; $display("FAIL reset_type: got %b want 000", JUMP_TYPE); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_taken: got %b want 0", pred_taken); end
    checks++; if (pred_target !== 64'd0) begin errors++; $display("FAIL reset_target: got %h want 0", pred_target); end
    fetch(2, 64'd16, 5'd0, 5'd0, 64'h100); #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_br_taken: got %b want 0", pred_taken); end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_btype_training();
    fetch(2, 64'd16, 5'd0, 5'd0, 64'h100); #1;
    checks++; if (JUMP_TYPE !== 3'b010) begin errors++; $display("FAIL br_type: got %b want 010", JUMP_TYPE); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL br_init_taken: got %b want 0", pred_taken); end
    checks++; if (pred_target !== 64'd0) begin errors++; $display("FAIL br_init_target: got %h want 0", pred_target); end
    cycle();
    idle(); upd_valid = 1'b1; upd_pc = 64'h100; upd_taken = 1'b1;
    cycle(); cycle();
    upd_valid = 1'b0;
    fetch(2, 64'd16, 5'd0, 5'd0, 64'h100); #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL br_trained_taken: got %b want 1", pred_taken); end
    checks++; if (pred_target !== 64'h110) begin errors++; $display("FAIL br_trained_target: got %h want 110", pred_target); end
    cycle();
    idle(); upd_valid = 1'b1; upd_taken = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    upd_taken = 1'b0;
    cycle();
    upd_valid = 1'b0;
    fetch(2, 64'd16, 5'd0, 5'd0, 64'h100); #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL br_sat_taken: got %b want 1", pred_taken); end
    checks++; if (pred_target !== 64'h110) begin errors++; $display("FAIL br_sat_target: got %h want 110", pred_target); end
    cycle();
  endtask

  task automatic test_jal_wrap();
    fetch(1, 64'h20, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFF0); #1;
    checks++; if (JUMP_TYPE !== 3'b001) begin errors++; $display("FAIL jal_type: got %b want 001", JUMP_TYPE); end
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL jal_taken: got %b want 1", pred_taken); end
    checks++; if (pred_target !== 64'h10) begin errors++; $display("FAIL jal_wrap_target: got %h want 10", pred_target); end
    cycle();
  endtask

  task automatic test_same_cycle();
    fetch(2, 64'hFFFF_FFFF_FFFF_FFF8, 5'd0, 5'd0, 64'h140);
    upd_valid = 1'b1; upd_pc = 64'h140; upd_taken = 1'b1; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL same_cycle_old: got %b want 0", pred_taken); end
    cycle();
    upd_valid = 1'b0; #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL same_cycle_new: got %b want 1", pred_taken); end
    checks++; if (pred_target !== 64'h138) begin errors++; $display("FAIL same_cycle_target: got %h want 138", pred_target); end
    upd_valid = 1'b1; upd_taken = 1'b0; #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL same_cycle_dec_old: got %b want 1", pred_taken); end
    cycle();
    upd_valid = 1'b0; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL same_cycle_dec_new: got %b want 0", pred_taken); end
    cycle();
  endtask

  task automatic test_reset_mid();
    idle(); upd_valid = 1'b1; upd_pc = 64'h180; upd_taken = 1'b1;
    cycle(); cycle();
    upd_valid = 1'b0;
    fetch(2, 64'h40, 5'd0, 5'd0, 64'h180); #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL mid_pre_taken: got %b want 1", pred_taken); end
    checks++; if (pred_target !== 64'h1C0) begin errors++; $display("FAIL mid_pre_target: got %h want 1c0", pred_target); end
    cycle();
    rst_n = 1'b0; #1;
    model_reset();
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL mid_reset_taken: got %b want 0", pred_taken); end
    fetch(2, 64'd16, 5'd0, 5'd0, 64'h100); #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL mid_reset_other: got %b want 0", pred_taken); end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_jalr_return();
    logic        want_taken;
    logic [63:0] want_target;
`ifdef BRANCH_PRED_RAS_EN
    want_taken = 1'b1; want_target = 64'h204;
`else
    want_taken = 1'b0; want_target = 64'h0;
`endif
    fetch(1, 64'h40, 5'd1, 5'd0, 64'h200); cycle();
    fetch(3, 64'h0, 5'd0, 5'd1, 64'h240); #1;
    checks++; if (JUMP_TYPE !== 3'b100) begin errors++; $display("FAIL jalr_type: got %b want 100", JUMP_TYPE); end
    checks++; if (pred_taken !== want_taken) begin errors++; $display("FAIL jalr_taken: got %b want %b", pred_taken, want_taken); end
    checks++; if (pred_target !== want_target) begin errors++; $display("FAIL jalr_target: got %h want %h", pred_target, want_target); end
    cycle();
  endtask

  task automatic test_ras_overflow();
    for (int i = 0; i <= RAS_DEPTH; i++) begin
      fetch(1, 64'h800, 5'd1, 5'd0, 64'h1000 + 64'(i) * 64'h100); cycle();
    end
    for (int i = 0; i <= RAS_DEPTH; i++) begin
      fetch(3, 64'h0, 5'd0, 5'd1, 64'h3000 + 64'(i) * 64'h10); #1;
      predict();
      checks++; if (pred_taken !== exp_taken) begin errors++; $display("FAIL ovf_taken[%0d]: got %b want %b", i, pred_taken, exp_taken); end
      checks++; if (pred_target !== exp_target) begin errors++; $display("FAIL ovf_target[%0d]: got %h want %h", i, pred_target, exp_target); end
      cycle();
    end
    fetch(3, 64'h0, 5'd0, 5'd1, 64'h3100); #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL ovf_empty_taken: got %b want 0", pred_taken); end
    cycle();
  endtask

  task automatic test_flush();
    fetch(1, 64'h100, 5'd1, 5'd0, 64'h500); cycle();
    fetch(1, 64'h100, 5'd5, 5'd0, 64'h600); flush = 1'b1; cycle();
    flush = 1'b0;
    fetch(3, 64'h0, 5'd0, 5'd1, 64'h700); #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL flush_taken: got %b want 0", pred_taken); end
    checks++; if (pred_target !== 64'd0) begin errors++; $display("FAIL flush_target: got %h want 0", pred_target); end
    cycle();
  endtask

  function automatic logic [4:0] pick_reg();
    logic [31:0] t;
    t = $urandom();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd5;
      default: return t[4:0];
    endcase
  endfunction

  task automatic test_random();
    int          kind;
    logic [31:0] t;
    logic [63:0] imm;
    logic [63:0] addr;
    for (int it = 0; it < 400; it++) begin
      kind = $urandom_range(0, 3);
      t = $urandom();
      case (kind)
        1: imm = {{43{t[20]}}, t[20:1], 1'b0};
        2: imm = {{51{t[12]}}, t[12:1], 1'b0};
        default: imm = {52'd0, t[11:0]};
      endcase
      addr = 64'($urandom_range(0, 31)) << 2;
      if ($urandom_range(0, 3) == 0) addr = {$urandom(), $urandom()} & ~64'd3;
      fetch(kind, imm, pick_reg(), pick_reg(), addr);
      if ($urandom_range(0, 4) == 0) pipeline_update = 1'b0;
      upd_valid = ($urandom_range(0, 1) == 1);
      upd_pc = 64'($urandom_range(0, 31)) << 2;
      upd_taken = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
      #1;
      predict();
      checks++; if (JUMP_TYPE !== exp_type) begin errors++; $display("FAIL rand_type[%0d]: got %b want %b", it, JUMP_TYPE, exp_type); end
      checks++; if (pred_taken !== exp_taken) begin errors++; $display("FAIL rand_taken[%0d]: got %b want %b", it, pred_taken, exp_taken); end
      checks++; if (pred_target !== exp_target) begin errors++; $display("FAIL rand_target[%0d]: got %h want %h", it, pred_target, exp_target); end
      cycle();
    end
    upd_valid = 1'b0; flush = 1'b0;
    idle();
  endtask

  initial begin
    test_reset();
    test_btype_training();
    test_jal_wrap();
    test_same_cycle();
    test_reset_mid();
    test_jalr_return();
    test_ras_overflow();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
